ram64_arbiter: RTL and testbench
================================

# ram64_arbiter

Two-port round-robin arbiter and access sequencer for a single RAM64 (16-bit × 64-word, combinational read, synchronous write on `load`). Two requesters share the one RAM64 port through a req/gnt/done handshake. The block drives the RAM64 `in`/`load`/`address` pins from registers and captures `out` for reads. It sits between the CPU-side clients (e.g. instruction fetch and data path) and the RAM64 instance.

## Interface
Parameters:
- `DATA_W`, 16, data width; must match RAM64.
- `ADDR_W`, 6, address width; must match RAM64.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_a` in 1: port A request; hold until `gnt_a`.
- `we_a` in 1: port A write (1) / read (0).
- `addr_a` in ADDR_W: port A address.
- `wdata_a` in DATA_W: port A write data.
- `gnt_a` out 1: one-cycle pulse, command accepted.
- `done_a` out 1: one-cycle pulse, access complete.
- `req_b`, `we_b`, `addr_b`, `wdata_b`, `gnt_b`, `done_b`: identical for port B.
- `rdata` out DATA_W: read data, valid while `done_a` or `done_b` is high and that access was a read.
- `ram_in` out DATA_W: to RAM64 `in`.
- `ram_load` out 1: to RAM64 `load`.
- `ram_address` out ADDR_W: to RAM64 `address`.
- `ram_out` in DATA_W: from RAM64 `out`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise pick a winner:
    - Only one req asserted: that port wins.
    - Both asserted: the port holding priority wins.
  - On the clock edge, register the winner's `addr` into `ram_address`, `wdata` into `ram_in`, and `we` into the owner's `ram_load` path. Record the owner and the op type, then go to ACCESS.
- ACCESS:
  - `ram_load` = registered `we`.
  - `gnt_<owner>` = 1.
  - RAM64 writes at the end of this cycle when `ram_load` = 1.
  - For reads, `ram_out` is captured into `rdata` at the end of this cycle.
  - Go to RESP.
- RESP:
  - `done_<owner>` = 1; `ram_load` = 0.
  - `rdata` holds the captured read value. After a write, `rdata` keeps its previous value.
  - Go to IDLE.
- Priority pointer: resets to A. After each grant it moves to the other port.
- Requester rules:
  - Keep `req` and the command stable until `gnt` is seen.
  - Drop `req` on the edge that ends the gnt cycle, unless another access is wanted.
  - `req` is ignored outside IDLE.
- Commands are never split or merged; every grant produces exactly one RAM64 access.

## Timing
- Request sampled in IDLE at cycle N:
  - `gnt` is high in N+1.
  - A write lands in RAM64 at the edge ending N+1.
  - `done` and `rdata` are valid in N+2.
- The FSM is back in IDLE in N+3, so the next grant can come no earlier than N+4. Maximum throughput is one access per 3 cycles.
- `gnt` and `done` are registered single-cycle pulses, never high for both ports at once.
- Reset values: state IDLE, pointer A, and all outputs 0 (`gnt_a`, `gnt_b`, `done_a`, `done_b`, `rdata`, `ram_in`, `ram_load`, `ram_address`).
- Reset mid-operation:
  - `rst_n` low clears everything asynchronously. `ram_load` drops immediately.
  - An in-flight write in ACCESS is aborted; the RAM word keeps its old value.
  - No `done` is issued for the aborted access.
- Simultaneous requests in IDLE: exactly one grant, chosen by the pointer. The loser stays pending.
- Address is used as-is; 6-bit wrap is inherent (63 + 1 is not generated here).

## Configuration
- `RAM64_ARB_FIXED_PRIO_EN`
  - Defined: port A always wins a simultaneous request; the pointer is removed. Port B can be starved by a continuous `req_a`.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single-port write then read: A writes `addr` 6'd10 with `wdata` 16'hBEEF; B then reads addr 10.
  - `gnt_a` in N+1, `done_a` in N+2.
  - The read returns `done_b` with `rdata` = 16'hBEEF.
- Collision: in the same cycle, A writes addr 1 = 16'h1111 and B writes addr 1 = 16'h2222, then A reads addr 1.
  - Grant order is A then B.
  - The read returns 16'h2222.
- Fairness: `req_a` and `req_b` held high continuously for 8 accesses.
  - Grants alternate A, B, A, B, …
  - Never two consecutive grants to one port.
  - Grants are exactly 3 cycles apart.
- Reset abort: A writes addr 5 = 16'h5555 over an old value of 16'h0A0A. Pull `rst_n` low mid-ACCESS.
  - `ram_load` goes to 0 immediately; all outputs read 0.
  - A later read of addr 5 returns 16'h0A0A.
- With `RAM64_ARB_FIXED_PRIO_EN` defined: `req_a` and `req_b` both held high.
  - Only `gnt_a` pulses.
  - Once `req_a` drops, `gnt_b` follows at the next IDLE.
- Read of an address never written, after reset: `rdata` equals the RAM64 content.
  - Check that `done` is a single-cycle pulse and `rdata` is stable in the `done` cycle.

Source files
------------

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: two-port round-robin arbiter and access sequencer for a
// single RAM64 (DATA_W x 64 words, combinational read, synchronous write).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_x/we_x/addr_x/wdata_x       requester x command (x = a, b), held until gnt_x
//   gnt_x                           one-cycle pulse, command accepted (RAM access cycle)
//   done_x                          one-cycle pulse, access complete
//   rdata                           read data, valid with done_x after a read
//   ram_in/ram_load/ram_address     registered drive of the RAM64 pins
//   ram_out                         RAM64 combinational read data
//
// Configuration macro: RAM64_ARB_FIXED_PRIO_EN
//   defined   -> port A always wins a simultaneous request, no pointer
//   undefined -> round-robin pointer, resets to A, flips after each grant
module ram64_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              done_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                owner_b, owner_b_nxt;  // 1: port B owns the access
    logic                is_rd, is_rd_nxt;
    logic                win_b;
    logic                gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
    logic                ram_load_nxt;
    logic [DATA_W-1:0]   rdata_nxt, ram_in_nxt;
    logic [ADDR_W-1:0]   ram_address_nxt;

    // Winner selection among the current requests
`ifdef RAM64_ARB_FIXED_PRIO_EN
    assign win_b = req_b & ~req_a;
`else
    logic prio_b;  // 1: port B holds priority

    assign win_b = (req_a && req_b) ? prio_b : req_b;

    // Pointer moves to the port that just lost (or was not granted)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
        end else if (state == IDLE && (req_a || req_b)) begin
            prio_b <= ~win_b;
        end
    end
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_b     <= 1'b0;
            is_rd       <= 1'b0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            rdata       <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            ram_address <= '0;
        end else begin
            state       <= state_nxt;
            owner_b     <= owner_b_nxt;
            is_rd       <= is_rd_nxt;
            gnt_a       <= gnt_a_nxt;
            gnt_b       <= gnt_b_nxt;
            done_a      <= done_a_nxt;
            done_b      <= done_b_nxt;
            rdata       <= rdata_nxt;
            ram_in      <= ram_in_nxt;
            ram_load    <= ram_load_nxt;
            ram_address <= ram_address_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        owner_b_nxt     = owner_b;
        is_rd_nxt       = is_rd;
        gnt_a_nxt       = 1'b0;
        gnt_b_nxt       = 1'b0;
        done_a_nxt      = 1'b0;
        done_b_nxt      = 1'b0;
        rdata_nxt       = rdata;
        ram_in_nxt      = ram_in;
        ram_load_nxt    = 1'b0;
        ram_address_nxt = ram_address;

        unique case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_b_nxt     = win_b;
                    ram_address_nxt = win_b ? addr_b  : addr_a;
                    ram_in_nxt      = win_b ? wdata_b : wdata_a;
                    ram_load_nxt    = win_b ? we_b    : we_a;
                    is_rd_nxt       = win_b ? ~we_b   : ~we_a;
                    gnt_a_nxt       = ~win_b;
                    gnt_b_nxt       = win_b;
                    state_nxt       = ACCESS;
                end
            end
            ACCESS: begin
                // RAM64 read is combinational on the registered address
                if (is_rd) begin
                    rdata_nxt = ram_out;
                end
                done_a_nxt = ~owner_b;
                done_b_nxt = owner_b;
                state_nxt  = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter with a behavioural RAM64 model.
module tb_ram64_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [5:0]  addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, done_a, done_b, ram_load;
    logic [15:0] rdata, ram_in, ram_out;
    logic [5:0]  ram_address;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Observations from run_one
    logic [1:0]  o_gnt1, o_done2, o_done3;
    logic        o_load1;
    logic [5:0]  o_addr1;
    logic [15:0] o_rdata2, o_rdata2b;

    logic [15:0] mem [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM64 model: combinational read, write on load at the rising edge
    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    ram64_arbiter #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .done_a(done_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .done_b(done_b),
        .rdata(rdata), .ram_in(ram_in), .ram_load(ram_load),
        .ram_address(ram_address), .ram_out(ram_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated access from IDLE; returns in the following IDLE cycle
    task automatic run_one(input bit pb, input bit we, input logic [5:0] a,
                           input logic [15:0] d);
        if (pb) begin
            req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
        end
        step();
        o_gnt1  = {gnt_b, gnt_a};
        o_load1 = ram_load;
        o_addr1 = ram_address;
        req_a = 1'b0; req_b = 1'b0;
        step();
        o_done2  = {done_b, done_a};
        o_rdata2 = rdata;
        #4;
        o_rdata2b = rdata;
        step();
        o_done3 = {done_b, done_a};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({gnt_a, gnt_b, done_a, done_b, ram_load} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000", {gnt_a, gnt_b, done_a, done_b, ram_load});
        end
        n_cmp++;
        if ({rdata, ram_in, ram_address} !== 38'b0) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%h ram_in=%h addr=%h want 0", rdata, ram_in, ram_address);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        run_one(1'b0, 1'b1, 6'd10, 16'hBEEF);
        n_cmp++;
        if (o_gnt1 !== 2'b01 || o_load1 !== 1'b1 || o_addr1 !== 6'd10) begin
            n_err++;
            $display("FAIL wr_gnt: got gnt=%b load=%b addr=%0d want 01 1 10", o_gnt1, o_load1, o_addr1);
        end
        n_cmp++;
        if (o_done2 !== 2'b01) begin
            n_err++;
            $display("FAIL wr_done: got %b want 01", o_done2);
        end
        n_cmp++;
        if (mem[10] !== 16'hBEEF) begin
            n_err++;
            $display("FAIL wr_mem: got %h want BEEF", mem[10]);
        end
        run_one(1'b1, 1'b0, 6'd10, 16'h0000);
        n_cmp++;
        if (o_gnt1 !== 2'b10 || o_load1 !== 1'b0) begin
            n_err++;
            $display("FAIL rd_gnt: got gnt=%b load=%b want 10 0", o_gnt1, o_load1);
        end
        n_cmp++;
        if (o_done2 !== 2'b10 || o_rdata2 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_data: got done=%b rdata=%h want 10 BEEF", o_done2, o_rdata2);
        end
    endtask

    task automatic test_collision();
        int order [2];
        int n = 0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd1; wdata_a = 16'h1111;
        req_b = 1'b1; we_b = 1'b1; addr_b = 6'd1; wdata_b = 16'h2222;
        for (int i = 0; i < 20 && n < 2; i++) begin
            step();
            if (gnt_a) begin order[n] = 0; n++; req_a = 1'b0; end
            else if (gnt_b) begin order[n] = 1; n++; req_b = 1'b0; end
        end
        req_a = 1'b0; req_b = 1'b0;
        n_cmp++;
        if (n !== 2) begin
            n_err++;
            $display("FAIL coll_count: got %0d grants want 2", n);
        end else begin
            n_cmp++;
            if (order[0] !== 0 || order[1] !== 1) begin
                n_err++;
                $display("FAIL coll_order: got %0d,%0d want 0,1", order[0], order[1]);
            end
        end
        step();
        step();
        run_one(1'b0, 1'b0, 6'd1, 16'h0000);
        n_cmp++;
        if (o_done2 !== 2'b01 || o_rdata2 !== 16'h2222) begin
            n_err++;
            $display("FAIL coll_read: got done=%b rdata=%h want 01 2222", o_done2, o_rdata2);
        end
    endtask

    task automatic test_fairness();
        int who [8];
        int at [8];
        int n = 0;
        int last_g = 0;
        // Read from B first so the pointer sits at A before the burst
        run_one(1'b1, 1'b0, 6'd10, 16'h0000);
        n_cmp++;
        if (o_rdata2 !== 16'hBEEF) begin
            n_err++;
            $display("FAIL fair_pre: got %h want BEEF", o_rdata2);
        end
        req_a = 1'b1; we_a = 1'b0; addr_a = 6'd2;
        req_b = 1'b1; we_b = 1'b0; addr_b = 6'd3;
        for (int i = 0; i < 60 && n < 8; i++) begin
            step();
            n_cmp++;
            if (gnt_a && gnt_b) begin
                n_err++;
                $display("FAIL fair_both: got both grants at cycle %0d want one", cyc);
            end
            if (gnt_a || gnt_b) begin
                who[n] = gnt_b ? 1 : 0;
                at[n] = cyc;
                n++;
            end
        end
        n_cmp++;
        if (n !== 8) begin
            n_err++;
            $display("FAIL fair_count: got %0d grants want 8", n);
        end else begin
            last_g = at[7];
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
`ifdef RAM64_ARB_FIXED_PRIO_EN
                if (who[k] !== 0) begin
`else
                if (who[k] !== (k % 2)) begin
`endif
                    n_err++;
                    $display("FAIL fair_who[%0d]: got port %0d", k, who[k]);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (at[k] - at[k-1] !== 3) begin
                        n_err++;
                        $display("FAIL fair_gap[%0d]: got %0d want 3", k, at[k] - at[k-1]);
                    end
                end
            end
        end
`ifdef RAM64_ARB_FIXED_PRIO_EN
        // Drop A in the gnt cycle; B should win at the next IDLE
        req_a = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || cyc - last_g !== 3) begin
            n_err++;
            $display("FAIL fixed_b: got gnt_b=%b gnt_a=%b gap=%0d want 1 0 3", gnt_b, gnt_a, cyc - last_g);
        end
`endif
        req_a = 1'b0; req_b = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_abort();
        req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 16'h5555;
        step();
        n_cmp++;
        if (gnt_a !== 1'b1 || ram_load !== 1'b1) begin
            n_err++;
            $display("FAIL abort_access: got gnt_a=%b load=%b want 1 1", gnt_a, ram_load);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_a, gnt_b, done_a, done_b, ram_load, rdata, ram_in, ram_address} !== 43'b0) begin
            n_err++;
            $display("FAIL abort_outs: got load=%b gnt=%b rdata=%h ram_in=%h addr=%h want 0",
                     ram_load, gnt_a, rdata, ram_in, ram_address);
        end
        req_a = 1'b0;
        step();
        n_cmp++;
        if (mem[5] !== 16'h0A0A) begin
            n_err++;
            $display("FAIL abort_mem: got %h want 0A0A", mem[5]);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({done_a, done_b} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_nodone: got %b want 00", {done_a, done_b});
        end
        run_one(1'b0, 1'b0, 6'd5, 16'h0000);
        n_cmp++;
        if (o_rdata2 !== 16'h0A0A) begin
            n_err++;
            $display("FAIL abort_read: got %h want 0A0A", o_rdata2);
        end
    endtask

    task automatic test_unwritten_read();
        run_one(1'b1, 1'b0, 6'd33, 16'h0000);
        n_cmp++;
        if (o_done2 !== 2'b10 || o_rdata2 !== 16'hC021) begin
            n_err++;
            $display("FAIL unw_read: got done=%b rdata=%h want 10 C021", o_done2, o_rdata2);
        end
        n_cmp++;
        if (o_done3 !== 2'b00) begin
            n_err++;
            $display("FAIL unw_pulse: got done=%b after done cycle want 00", o_done3);
        end
        n_cmp++;
        if (o_rdata2b !== 16'hC021) begin
            n_err++;
            $display("FAIL unw_stable: got %h late in done cycle want C021", o_rdata2b);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hC000 + 16'(i);
        mem[5] = 16'h0A0A;
        test_reset();
        test_write_read();
        test_collision();
        test_fairness();
        test_reset_abort();
        test_unwritten_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
